rptr_empty_ctrl: RTL

RPTR_EMPTY_CTRL -- requirements
Module: rptr_empty_ctrl

---
 rtl/rptr_empty_ctrl.sv | 78 +++++++
 1 files changed

// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer, empty, almost-empty, level and sticky underflow controller
// for an asynchronous FIFO; consumes the synchronized Gray write pointer.
module rptr_empty_ctrl #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                rundf_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                raempty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                rundf
);

  // Threshold widened by one bit so AEMPTY_THRESH = 2^ADDRSIZE compares cleanly.
  localparam logic [ADDRSIZE+1:0] THRESH = (ADDRSIZE+2)'(AEMPTY_THRESH);

  function automatic logic [ADDRSIZE:0] bin2gray(input logic [ADDRSIZE:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDRSIZE:0] rbin;
  logic              pop_p0;
  logic              undf_p0;
  logic [ADDRSIZE:0] rbinnext_p0;
  logic [ADDRSIZE:0] rgraynext_p0;
  logic [ADDRSIZE:0] wbin_sync_p0;
  logic [ADDRSIZE:0] level_next_p0;

  always_comb begin
    pop_p0        = rinc & ~rempty;
    undf_p0       = rinc & rempty;
    rbinnext_p0   = rbin + {{ADDRSIZE{1'b0}}, pop_p0};
    rgraynext_p0  = bin2gray(rbinnext_p0);
    wbin_sync_p0  = gray2bin(rq2_wptr);
    level_next_p0 = wbin_sync_p0 - rbinnext_p0;
  end

  // Stage boundary: every output is registered from the next-state values above.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rbin    <= '0;
      rptr    <= '0;
      rempty  <= 1'b1;
      raempty <= 1'b1;
      rlevel  <= '0;
      rundf   <= 1'b0;
    end else begin
      rbin    <= rbinnext_p0;
      rptr    <= rgraynext_p0;
      rempty  <= (rgraynext_p0 == rq2_wptr);
      raempty <= ({1'b0, level_next_p0} <= THRESH);
      rlevel  <= level_next_p0;
      if (undf_p0) begin
        rundf <= 1'b1;
      end else if (rundf_clr) begin
        rundf <= 1'b0;
      end
    end
  end

  assign raddr = rbin[ADDRSIZE-1:0];

endmodule
